// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-stepped Pong ball, paddle-bounce, scoring and game-state sequencer
module pong_game_ctrl #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int PAD_X1      = 16,
    parameter int PAD_X2      = 616,
    parameter int PAD_W       = 8,
    parameter int PAD_H       = 64,
    parameter int BALL_SZ     = 8,
    parameter int SPEED       = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 60
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       start_export,
    input  logic       frame_tick,
    input  logic [9:0] p1y_export,
    input  logic [9:0] p2y_export,
    output logic [9:0] bx_export,
    output logic [9:0] by_export,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [2:0] state_o,
    output logic       hit_pulse,
    output logic       point_pulse
);
    typedef enum logic [2:0] {IDLE, SERVE, PLAY, STEP, POINT, OVER} state_t;
    localparam logic [9:0]  CX         = 10'(SCREEN_W / 2 - BALL_SZ / 2);
    localparam logic [9:0]  CY         = 10'(SCREEN_H / 2 - BALL_SZ / 2);
    localparam logic [10:0] FL         = 11'(PAD_X1 + PAD_W);
    localparam logic [10:0] FR         = 11'(PAD_X2 - BALL_SZ);
    localparam logic [10:0] XMAX       = 11'(SCREEN_W - BALL_SZ);
    localparam logic [10:0] YMAX       = 11'(SCREEN_H - BALL_SZ);
    localparam logic [10:0] SPD        = 11'(SPEED);
    localparam logic [10:0] BSZ        = 11'(BALL_SZ);
    localparam logic [10:0] PH         = 11'(PAD_H);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_DELAY - 1);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
    state_t      state, state_n;
    logic [9:0]  bx, by, bx_n, by_n, bx_step, by_step;
    logic [3:0]  s1_n, s2_n, s_cur, s_new;
    logic [7:0]  cnt, cnt_n;
    logic        dx, dy, dx_n, dy_n, p1_scored, p1_scored_n, hit_n, start_q;
    logic [10:0] bx_w, by_w, p1_w, p2_w;
    logic        y_top, y_bot, dy_step, ov1, ov2, hit_l, hit_r, miss_l, miss_r, start_rise;
    assign bx_w       = {1'b0, bx};
    assign by_w       = {1'b0, by};
    assign p1_w       = {1'b0, p1y_export};
    assign p2_w       = {1'b0, p2y_export};
    assign start_rise = start_export & ~start_q;
    assign y_top      = ~dy & (by_w <= SPD);
    assign y_bot      = dy & (by_w + SPD >= YMAX);
    assign by_step    = 10'(y_top ? 11'd0 : y_bot ? YMAX : dy ? by_w + SPD : by_w - SPD);
    assign dy_step    = y_top | (dy & ~y_bot);
    // paddle overlap uses the pre-move ball Y
    assign ov1        = (by_w + BSZ > p1_w) && (by_w < p1_w + PH);
    assign ov2        = (by_w + BSZ > p2_w) && (by_w < p2_w + PH);
    assign hit_l      = ~dx && (bx_w >= FL) && (bx_w < FL + SPD) && ov1;
    assign hit_r      = dx && (bx_w <= FR) && (bx_w + SPD > FR) && ov2;
    assign miss_l     = ~dx && (bx_w < SPD);
    assign miss_r     = dx && (bx_w + SPD > XMAX);
    assign bx_step    = 10'(hit_l ? FL : hit_r ? FR : miss_l ? 11'd0 : miss_r ? XMAX :
                            dx ? bx_w + SPD : bx_w - SPD);
    assign s_cur      = p1_scored ? score_p1 : score_p2;
    assign s_new      = (&s_cur) ? s_cur : s_cur + 4'd1;
    always_comb begin
        state_n     = state;
        bx_n        = bx;
        by_n        = by;
        dx_n        = dx;
        dy_n        = dy;
        s1_n        = score_p1;
        s2_n        = score_p2;
        cnt_n       = cnt;
        hit_n       = 1'b0;
        p1_scored_n = p1_scored;
        case (state)
            IDLE, OVER: if (start_rise) begin
                s1_n    = '0;
                s2_n    = '0;
                bx_n    = CX;
                by_n    = CY;
                cnt_n   = '0;
                dx_n    = 1'b1;
                dy_n    = 1'b1;
                state_n = SERVE;
            end
            SERVE: if (frame_tick) begin
                cnt_n   = (cnt == SERVE_LAST) ? 8'd0 : cnt + 8'd1;
                state_n = (cnt == SERVE_LAST) ? PLAY : SERVE;
            end
            PLAY: if (frame_tick) state_n = STEP;
            STEP: begin
                bx_n        = bx_step;
                by_n        = by_step;
                dy_n        = dy_step;
                dx_n        = hit_l ? 1'b1 : hit_r ? 1'b0 : dx;
                hit_n       = hit_l | hit_r;
                p1_scored_n = miss_r;
                state_n     = (miss_l | miss_r) ? POINT : PLAY;
            end
            POINT: begin
                s1_n    = p1_scored ? s_new : score_p1;
                s2_n    = p1_scored ? score_p2 : s_new;
                state_n = (s_new == WIN) ? OVER : SERVE;
                if (s_new != WIN) begin
                    bx_n  = CX;
                    by_n  = CY;
                    cnt_n = '0;
                    dx_n  = p1_scored;
                    dy_n  = ~dy;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state       <= IDLE;
            bx          <= CX;
            by          <= CY;
            dx          <= 1'b1;
            dy          <= 1'b1;
            score_p1    <= '0;
            score_p2    <= '0;
            cnt         <= '0;
            hit_pulse   <= 1'b0;
            point_pulse <= 1'b0;
            start_q     <= 1'b0;
            p1_scored   <= 1'b0;
        end else begin
            state       <= state_n;
            bx          <= bx_n;
            by          <= by_n;
            dx          <= dx_n;
            dy          <= dy_n;
            score_p1    <= s1_n;
            score_p2    <= s2_n;
            cnt         <= cnt_n;
            hit_pulse   <= hit_n;
            point_pulse <= (state == POINT);
            start_q     <= start_export;
            p1_scored   <= p1_scored_n;
        end
    end
    assign bx_export = bx;
    assign by_export = by;
    assign state_o   = state;
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Hardware game sequencer for the Pong system.
- Owns ball position, ball direction, scores and the game state machine.
- Advances once per video frame tick. Paddle Y positions come from the processor; ball X/Y go to the video renderer.
- Replaces per-frame ball stepping in software with a deterministic, cycle-exact datapath.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
PAD_X1, 16, left paddle left edge
PAD_X2, 616, right paddle left edge
PAD_W, 8, paddle width
PAD_H, 64, paddle height
BALL_SZ, 8, ball side length
SPEED, 4, pixels moved per axis per frame
WIN_SCORE, 9, score that ends the game
SERVE_DELAY, 60, frame ticks the ball waits at centre before a serve

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous, active-high reset
start_export  in  1  start button level; rising edge used
frame_tick  in  1  one-cycle pulse per video frame
p1y_export  in  10  left paddle top Y
p2y_export  in  10  right paddle top Y
bx_export  out  10  ball left X
by_export  out  10  ball top Y
score_p1  out  4  left player score
score_p2  out  4  right player score
state_o  out  3  IDLE=0 SERVE=1 PLAY=2 STEP=3 POINT=4 OVER=5
hit_pulse  out  1  one-cycle pulse on paddle bounce
point_pulse  out  1  one-cycle pulse when a point is scored

Behaviour:
- Reset (sync, high; overrides everything, including mid-STEP) sets:
  - bx=316, by=236 (centre, CX=SCREEN_W/2-BALL_SZ/2, CY=SCREEN_H/2-BALL_SZ/2)
  - scores 0, state IDLE
  - dx=right, dy=down, serve_cnt=0
  - pulses 0, start edge register 0
- start_export is registered once; start_rise = cur & ~prev.
- IDLE: on start_rise -> scores 0, ball at centre, serve_cnt 0, dx right, dy down, go to SERVE.
- SERVE: ball held at centre. Each frame_tick increments serve_cnt. When a tick arrives with serve_cnt==SERVE_DELAY-1, clear serve_cnt and go to PLAY.
- PLAY: frame_tick -> STEP on the next cycle. Ticks arriving in any other state (STEP, POINT, OVER, IDLE) are dropped.
- STEP (exactly 1 cycle): sample p1y/p2y and compute in 11-bit unsigned arithmetic; the new bx/by are visible 2 cycles after the tick cycle.
  - Y axis:
    - up and by<=SPEED: by=0, dy=down.
    - down and by+SPEED>=SCREEN_H-BALL_SZ: by=SCREEN_H-BALL_SZ, dy=up.
    - otherwise by±SPEED.
  - Vertical overlap with paddle: (by+BALL_SZ > py) and (by < py+PAD_H), using the pre-move by.
  - Left face FL=PAD_X1+PAD_W:
    - moving left, bx>=FL, bx-SPEED<FL, overlap p1 -> bx=FL, dx=right, hit_pulse.
  - Right face FR=PAD_X2-BALL_SZ:
    - moving right, bx<=FR, bx+SPEED>FR, overlap p2 -> bx=FR, dx=left, hit_pulse.
  - Miss:
    - moving left and bx<SPEED -> p2 scores, bx=0.
    - moving right and bx+SPEED>SCREEN_W-BALL_SZ -> p1 scores, bx=SCREEN_W-BALL_SZ.
    - Either miss goes to POINT.
  - Otherwise bx±SPEED, back to PLAY.
  - Wall and paddle bounce in the same STEP: both applied.
- POINT (1 cycle):
  - point_pulse=1; increment the scorer's score (saturating at 15).
  - If new score==WIN_SCORE -> OVER.
  - Else ball to centre, serve_cnt 0, dx toward the conceding player, dy inverted, go to SERVE.
- OVER: ball and scores frozen. start_rise behaves as in IDLE (new game).
- start_rise in SERVE/PLAY/STEP/POINT is ignored.
- hit_pulse and point_pulse are high for exactly one cycle, otherwise 0.

Test Plan:
- Reset then start_export 0->1 -> state IDLE->SERVE; bx=316, by=236, scores 0. After 60 ticks, state PLAY.
- PLAY, bx=316, by=236, dx right, dy down, one tick -> 2 cycles later bx=320, by=240; state back to PLAY.
- by=474, dy down, tick -> by=472, dy up; next tick -> by=468.
- Ball at bx=26, by=200, dx left, p1y=180, tick -> bx=24, dx right, hit_pulse 1 cycle. Same with p1y=300 -> bx=22, no hit; continue ticks until bx<4 -> score_p2=1, point_pulse, state SERVE, ball centre, dx left.
- score_p1=8, right miss -> score_p1=9, state OVER; further ticks do not change bx/by; start rise -> scores 0, SERVE.
- Assert reset_reset during STEP -> next cycle all outputs at reset values, state IDLE; frame_tick during STEP is dropped (one step only).
